// File: rtl/pcs_pkg.sv
// Shared definitions for the program counting system.
// Holds the return-address width, the stack depth and the stack operation decode.
package pcs_pkg;

  localparam int RA_WIDTH       = 16;
  localparam int RA_STACK_DEPTH = 8;

  typedef logic [RA_WIDTH-1:0] ra_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/ra_stack_mem.sv
// Return-address register file: one synchronous write port, one asynchronous read port.
// Contents are not reset; the stack pointer and count decide which entries are valid.
module ra_stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ra_stack.sv
// Circular hardware return-address stack with registered restore output.
// Overflow overwrites the oldest entry; both overflow and underflow are sticky.
module ra_stack
  import pcs_pkg::*;
#(
  parameter int WIDTH = RA_WIDTH,
  parameter int DEPTH = RA_STACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] RA_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] RArestore,
  output logic             restore,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] rarestore_q, rarestore_d;
  logic             restore_q, restore_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] top_ptr;
  logic [WIDTH-1:0] top_data;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  stack_op_e        op;

  assign op      = decode_op(push, pop);
  assign top_ptr = sp_q - PTR_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));

  // A swap on a non-empty stack replaces the top; a swap on an empty stack bypasses memory.
  assign mem_we    = push && !(pop && empty);
  assign mem_waddr = (op == OP_SWAP) ? top_ptr : sp_q;

  ra_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(RA_in),
    .raddr(top_ptr),
    .rdata(top_data)
  );

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    rarestore_d = rarestore_q;
    restore_d   = 1'b0;
    overflow_d  = overflow_q && !clear_err;
    underflow_d = underflow_q && !clear_err;
    unique case (op)
      OP_PUSH: begin
        sp_d = sp_q + PTR_W'(1);
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + (PTR_W+1)'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          rarestore_d = top_data;
          restore_d   = 1'b1;
          sp_d        = top_ptr;
          count_d     = count_q - (PTR_W+1)'(1);
        end
      end
      OP_SWAP: begin
        rarestore_d = empty ? RA_in : top_data;
        restore_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q        <= '0;
      count_q     <= '0;
      rarestore_q <= '0;
      restore_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      rarestore_q <= rarestore_d;
      restore_q   <= restore_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign RArestore = rarestore_q;
  assign restore   = restore_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ra_stack.sv
// Directed bench for ra_stack: a vector table of per-cycle inputs and expected
// post-edge outputs, plus hand-written sequences for reset and clear_err races.
module tb_ra_stack;

  logic        clk;
  logic        reset_n;
  logic        push;
  logic        pop;
  logic [15:0] RA_in;
  logic        clear_err;
  logic [15:0] RArestore;
  logic        restore;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  typedef struct {
    logic        rst_n;
    logic        push;
    logic        pop;
    logic        clr;
    logic [15:0] ra;
    logic        e_rs;
    logic [15:0] e_ra;
    logic [3:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  ra_stack #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .RA_in    (RA_in),
    .clear_err(clear_err),
    .RArestore(RArestore),
    .restore  (restore),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL txn=%0d %s actual=0x%0h required=0x%0h", txn, name, act, exp);
    end
  endtask

  task automatic add(input logic rst_n, input logic p, input logic q, input logic clr,
                     input logic [15:0] ra, input logic e_rs, input logic [15:0] e_ra,
                     input logic [3:0] e_cnt, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst_n = rst_n; v.push = p; v.pop = q; v.clr = clr; v.ra = ra;
    v.e_rs = e_rs; v.e_ra = e_ra; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check every output.
  task automatic apply(input vec_t v);
    reset_n   = v.rst_n;
    push      = v.push;
    pop       = v.pop;
    clear_err = v.clr;
    RA_in     = v.ra;
    @(posedge clk);
    #1;
    txn++;
    $display("txn=%0d rst_n=%0b push=%0b pop=%0b clr=%0b ra=%04h -> restore=%0b RArestore=%04h count=%0d ovf=%0b unf=%0b",
             txn, v.rst_n, v.push, v.pop, v.clr, v.ra, restore, RArestore, count, overflow, underflow);
    check("restore",   int'(restore),   int'(v.e_rs));
    check("RArestore", int'(RArestore), int'(v.e_ra));
    check("count",     int'(count),     int'(v.e_cnt));
    check("empty",     int'(empty),     int'(v.e_cnt == 4'd0));
    check("full",      int'(full),      int'(v.e_cnt == 4'd8));
    check("overflow",  int'(overflow),  int'(v.e_ovf));
    check("underflow", int'(underflow), int'(v.e_unf));
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0; RA_in = '0;

    // 1: reset, three pushes, three back-to-back pops
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0011, 0, 16'h0000, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0022, 0, 16'h0000, 2, 0, 0);
    add(1, 1, 0, 0, 16'h0033, 0, 16'h0000, 3, 0, 0);
    add(1, 0, 1, 0, 16'h0000, 1, 16'h0033, 2, 0, 0);
    add(1, 0, 1, 0, 16'h0000, 1, 16'h0022, 1, 0, 0);
    add(1, 0, 1, 0, 16'h0000, 1, 16'h0011, 0, 0, 0);
    // 2: pop while empty, then clear_err
    add(1, 0, 1, 0, 16'h0000, 0, 16'h0011, 0, 0, 1);
    add(1, 0, 0, 1, 16'h0000, 0, 16'h0011, 0, 0, 0);
    // 3: ten pushes into an eight-deep stack, eight pops, then one more pop
    for (int i = 0; i < 10; i++) begin
      add(1, 1, 0, 0, 16'h0100 + 16'(i), 0, 16'h0011,
          (i < 8) ? 4'(i + 1) : 4'd8, (i >= 8), 0);
    end
    for (int i = 0; i < 8; i++) begin
      add(1, 0, 1, 0, 16'h0000, 1, 16'h0109 - 16'(i), 4'(7 - i), 1, 0);
    end
    add(1, 0, 1, 0, 16'h0000, 0, 16'h0102, 0, 1, 1);
    add(1, 0, 0, 1, 16'h0000, 0, 16'h0102, 0, 0, 0);
    // 4: replace top with simultaneous push and pop
    add(1, 1, 0, 0, 16'h00AA, 0, 16'h0102, 1, 0, 0);
    add(1, 1, 1, 0, 16'h00BB, 1, 16'h00AA, 1, 0, 0);
    add(1, 0, 1, 0, 16'h0000, 1, 16'h00BB, 0, 0, 0);
    // 5: bypass on empty stack, then restore falls
    add(1, 1, 1, 0, 16'h1234, 1, 16'h1234, 0, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 0, 16'h1234, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // 6: reset wins over a pop with valid entries on the stack
    v = '{rst_n:1, push:1, pop:0, clr:0, ra:16'h0005, e_rs:0, e_ra:16'h1234, e_cnt:1, e_ovf:0, e_unf:0};
    apply(v);
    v.ra = 16'h0006; v.e_cnt = 2;
    apply(v);
    v = '{rst_n:0, push:0, pop:1, clr:0, ra:16'h0000, e_rs:0, e_ra:16'h0000, e_cnt:0, e_ovf:0, e_unf:0};
    apply(v);
    v.rst_n = 1; v.e_unf = 1;
    apply(v);

    // Error set beats clear_err in the same cycle; clear alone then drops it.
    v.clr = 1;
    apply(v);
    v.pop = 0; v.e_unf = 0;
    apply(v);

    // Fill, then push and pop together while full: no overflow, count stays 8.
    for (int i = 0; i < 8; i++) begin
      v = '{rst_n:1, push:1, pop:0, clr:0, ra:16'h0200 + 16'(i), e_rs:0, e_ra:16'h0000,
            e_cnt:4'(i + 1), e_ovf:0, e_unf:0};
      apply(v);
    end
    v = '{rst_n:1, push:1, pop:1, clr:0, ra:16'h0300, e_rs:1, e_ra:16'h0207, e_cnt:8, e_ovf:0, e_unf:0};
    apply(v);
    v = '{rst_n:1, push:0, pop:1, clr:0, ra:16'h0000, e_rs:1, e_ra:16'h0300, e_cnt:7, e_ovf:0, e_unf:0};
    apply(v);
    v.e_ra = 16'h0206; v.e_cnt = 6;
    apply(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ra_stack.md
Name: ra_stack

Overview:
- Hardware return-address stack; the storage counterpart to the program counting system.
- On call, the controller pushes the current RA value (the PC+1 captured by the PC/RA block).
- On return, the stack pops the saved value and presents it on RArestore with a one-cycle restore strobe. The controller then asserts restore and writeRA into the PC/RA block, which reloads RA for nested returns.
- Circular storage: overflow overwrites the oldest entry rather than stalling.

Parameters:
- WIDTH, 16, data width of a return address.
- DEPTH, 8, number of stack entries; must be a power of two, at least 2.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- push  input  1  save RA_in as the new top this cycle.
- pop  input  1  remove the top entry and return it next cycle.
- RA_in  input  WIDTH  return address to save; driven from the PC/RA block RA output.
- clear_err  input  1  clears the sticky overflow and underflow flags.
- RArestore  output  WIDTH  popped address, registered.
- restore  output  1  one-cycle pulse: RArestore is valid this cycle.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0, combinational from count.
- full  output  1  count==DEPTH, combinational from count.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (reset_n==0 at rising edge):
  - top pointer=0, count=0, RArestore=0, restore=0, overflow=0, underflow=0.
  - Memory contents are don't-care.
  - Reset wins over every other input in the same cycle, including mid-operation; any pending restore is dropped.
- Internal state:
  - sp, a PTR_W-bit pointer to the next free slot; wraps modulo DEPTH.
  - The top entry is mem[sp-1] (mod DEPTH).
- restore defaults to 0 every cycle unless set by a case below.
- Push only, not full: mem[sp]<=RA_in; sp<=sp+1; count<=count+1.
- Push only, full:
  - mem[sp]<=RA_in; sp<=sp+1; count stays DEPTH; overflow<=1.
  - The oldest entry is lost.
  - After DEPTH+k pushes, the last DEPTH values are retained.
- Pop only, not empty: RArestore<=mem[sp-1]; restore<=1 (next cycle); sp<=sp-1; count<=count-1.
- Pop only, empty:
  - restore stays 0; RArestore holds its previous value; underflow<=1.
  - sp and count are unchanged.
- Push and pop, not empty:
  - RArestore<=old top; restore<=1.
  - mem[sp-1]<=RA_in (replace top).
  - sp and count are unchanged. This also holds when full; overflow is not set.
- Push and pop, empty:
  - Bypass: RArestore<=RA_in; restore<=1.
  - count stays 0; underflow is not set.
- Latency: exactly 1 cycle from pop sampled to restore high; back-to-back pops give back-to-back restore pulses.
- clear_err:
  - Clears overflow and underflow in the next cycle.
  - If a new error event occurs in the same cycle, the error set wins.
- Memory:
  - Single write port.
  - Read is combinational from mem[sp-1], so popped data is captured into the RArestore register in the same edge.

Decomposition:
- Shared package pcs_pkg:
  - RA_WIDTH=16 and RA_STACK_DEPTH=8 constants.
  - A return-address type of RA_WIDTH bits, shared with the PC/RA block.
- One sub-module, ra_stack_mem:
  - DEPTH x WIDTH register file.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- Pointer/count/flag control and output registers stay in ra_stack.

Test Plan:
1. Reset, then push 0x0011, 0x0022, 0x0033 on three cycles, then pop three consecutive cycles -> restore high on three consecutive cycles with RArestore 0x0033, 0x0022, 0x0011; count returns 3->0; empty=1.
2. From empty, single pop -> restore stays 0, RArestore unchanged, underflow=1. Then pulse clear_err -> underflow=0 next cycle.
3. Push 0x0100+i for i=0..9 (10 pushes, DEPTH=8) -> full=1, count=8, overflow=1. Then 8 pops -> returns 0x0109 down to 0x0102. A ninth pop -> underflow=1.
4. Push 0x00AA; then in one cycle push=1, pop=1, RA_in=0x00BB -> next cycle restore=1, RArestore=0x00AA, count=1. A following pop -> RArestore=0x00BB.
5. Empty, push=1, pop=1, RA_in=0x1234 -> next cycle restore=1, RArestore=0x1234, count=0, underflow=0.
6. Push 0x0005, 0x0006, then assert reset_n=0 for one cycle together with pop=1 -> restore=0, count=0, RArestore=0, flags 0. A subsequent pop -> underflow=1.
